pipe_hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates the enable (stall) and clear (flush) controls for the F/D/E/M/W pipeline registers.
- Generates the E-stage operand forwarding selects.
- Runs a small FSM that sequences reset bubbles and multi-cycle data-memory accesses via a req/ready handshake.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 58 +++++
 rtl/pipe_hazard_ctrl_fwd.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg (file pipe_hazard_ctrl_pkg.sv)
//  Purpose  : Shared types and constants for the RV32I pipeline hazard
//             controller: FSM state encoding, forwarding-select codes and
//             the register-index width.
//  Contents : REG_AW, FWD_RF / FWD_W / FWD_M, state_t {INIT, RUN, DWAIT}
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_AW = 5;

    // E-stage operand source selects
    localparam logic [1:0] FWD_RF = 2'b00;  // register file
    localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DWAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Bundle of pipeline-status inputs and hazard-control outputs
//             exchanged between the datapath and the hazard controller.
//  Modports : master - datapath side (drives register indices / flags,
//                      receives stall, flush, forwarding and dmem_req)
//             slave  - controller side (the reverse)
//  Params   : REG_AW - register-index width
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = pipe_pkg::REG_AW
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic [REG_AW-1:0] rd_m;
    logic [REG_AW-1:0] rd_w;
    logic              regwrite_m;
    logic              regwrite_w;
    logic              load_e;
    logic              pcsrc_e;
    logic              memacc_m;
    logic              dmem_ready;

    logic              dmem_req;
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic              flush_w;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
               regwrite_m, regwrite_w, load_e, pcsrc_e, memacc_m, dmem_ready,
        input  dmem_req, fwd_a_e, fwd_b_e,
               stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
               regwrite_m, regwrite_w, load_e, pcsrc_e, memacc_m, dmem_ready,
        output dmem_req, fwd_a_e, fwd_b_e,
               stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_unit
//  Purpose  : Combinational forwarding compare for one E-stage operand.
//             M-stage writer wins over W-stage writer; x0 is never forwarded.
//  Ports    : rs_e        in  REG_AW  source register in E
//             rd_m, rd_w  in  REG_AW  destination registers in M and W
//             regwrite_m  in  1       M writes the register file
//             regwrite_w  in  1       W writes the register file
//             fwd_sel     out 2       FWD_RF / FWD_W / FWD_M
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic [1:0]        fwd_sel
);

    logic w_rs_nz;

    assign w_rs_nz = (rs_e != '0);

    always_comb begin
        fwd_sel = FWD_RF;
        if (w_rs_nz && regwrite_m && (rs_e == rd_m)) begin
            fwd_sel = FWD_M;
        end else if (w_rs_nz && regwrite_w && (rs_e == rd_w)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard and sequencing controller for the 5-stage RV32I pipeline.
//             Produces stall/flush controls for the F/D/E/M/W registers,
//             the E-stage forwarding selects and the data-memory request.
//             A three-state FSM (INIT, RUN, DWAIT) inserts one reset bubble
//             cycle and holds the pipe across multi-cycle dmem accesses.
//  Ports    : clk        in   clock
//             rst_n      in   asynchronous active-low reset
//             hz         slave modport of pipe_hazard_ctrl_if
//             stall_cnt  out  CNT_W  cycles with stall_f in RUN/DWAIT  (opt)
//             flush_cnt  out  CNT_W  cycles with branch flush           (opt)
//  Options  : PIPE_PERF_CNT_EN - adds CNT_W parameter and the two counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave  hz
);

    state_t            r_state;

    logic [REG_AW-1:0] w_rs1_d;
    logic [REG_AW-1:0] w_rs2_d;
    logic [REG_AW-1:0] w_rd_e;
    logic              w_active;
    logic              w_mem_req;
    logic              w_mem_stall;
    logic              w_lduse_hz;
    logic              w_req;
    logic [3:0]        w_stall;     // {f, d, e, m}
    logic [3:0]        w_flush;     // {d, e, m, w}
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    assign w_rs1_d = hz.rs1_d;
    assign w_rs2_d = hz.rs2_d;
    assign w_rd_e  = hz.rd_e;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            case (r_state)
                INIT:    r_state <= RUN;
                RUN:     if (hz.memacc_m && !hz.dmem_ready) r_state <= DWAIT;
                DWAIT:   if (hz.dmem_ready)                 r_state <= RUN;
                default: r_state <= INIT;
            endcase
        end
    end

    assign w_active    = (r_state == RUN) || (r_state == DWAIT);

    // In DWAIT the request is held regardless of memacc_m: the M-stage
    // instruction is frozen by the stall, so the access is still pending.
    assign w_mem_req   = ((r_state == RUN) && hz.memacc_m) || (r_state == DWAIT);
    assign w_mem_stall = w_mem_req && !hz.dmem_ready;

    assign w_lduse_hz  = hz.load_e && (w_rd_e != '0) &&
                         ((w_rs1_d == w_rd_e) || (w_rs2_d == w_rd_e));

    // ------------------------------------------------------------------
    // Stall / flush decode. Reset is folded in combinationally so that
    // dmem_req drops and all registers are held/cleared the moment rst_n
    // falls, including mid-access.
    // ------------------------------------------------------------------
    always_comb begin
        w_req   = 1'b0;
        w_stall = 4'b0000;
        w_flush = 4'b0000;
        if (!rst_n) begin
            w_stall = 4'b1111;
            w_flush = 4'b1111;
        end else begin
            case (r_state)
                INIT: begin
                    w_stall = 4'b1000;
                    w_flush = 4'b1111;
                end
                RUN, DWAIT: begin
                    w_req = w_mem_req;
                    if (w_mem_stall) begin
                        // Freeze F..M; W gets a bubble. Branch and load-use
                        // are re-evaluated once E is released.
                        w_stall = 4'b1111;
                        w_flush = 4'b0001;
                    end else if (hz.pcsrc_e) begin
                        // Taken branch squashes D and E, overriding load-use.
                        w_flush = 4'b1100;
                    end else if (w_lduse_hz) begin
                        w_stall = 4'b1100;
                        w_flush = 4'b0100;
                    end
                end
                default: begin
                    w_stall = 4'b1111;
                    w_flush = 4'b1111;
                end
            endcase
        end
    end

    assign hz.dmem_req = w_req;
    assign hz.stall_f  = w_stall[3];
    assign hz.stall_d  = w_stall[2];
    assign hz.stall_e  = w_stall[1];
    assign hz.stall_m  = w_stall[0];
    assign hz.flush_d  = w_flush[3];
    assign hz.flush_e  = w_flush[2];
    assign hz.flush_m  = w_flush[1];
    assign hz.flush_w  = w_flush[0];

    // ------------------------------------------------------------------
    // Operand forwarding (state independent, forced to RF in reset)
    // ------------------------------------------------------------------
    fwd_unit #(
        .REG_AW     (REG_AW)
    ) u_fwd_a (
        .rs_e       (hz.rs1_e),
        .rd_m       (hz.rd_m),
        .rd_w       (hz.rd_w),
        .regwrite_m (hz.regwrite_m),
        .regwrite_w (hz.regwrite_w),
        .fwd_sel    (w_fwd_a)
    );

    fwd_unit #(
        .REG_AW     (REG_AW)
    ) u_fwd_b (
        .rs_e       (hz.rs2_e),
        .rd_m       (hz.rd_m),
        .rd_w       (hz.rd_w),
        .regwrite_m (hz.regwrite_m),
        .regwrite_w (hz.regwrite_w),
        .fwd_sel    (w_fwd_b)
    );

    assign hz.fwd_a_e = rst_n ? w_fwd_a : FWD_RF;
    assign hz.fwd_b_e = rst_n ? w_fwd_b : FWD_RF;

`ifdef PIPE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_active && w_stall[3]) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            // flush_d in RUN/DWAIT can only come from a taken branch
            if (w_active && w_flush[3]) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl: reset/INIT bubble,
//             vector table in RUN, hand-written multi-cycle memory sequences,
//             and randomized traffic against a cycle-level reference model.
//  Options  : PIPE_PERF_CNT_EN - also checks stall_cnt / flush_cnt
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_AW    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .hz        (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       rwm, rww, load, pcsrc, memacc, ready;
        logic       req;
        logic [3:0] stall;   // {f,d,e,m}
        logic [3:0] flush;   // {d,e,m,w}
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vt [13];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [3:0] st,
                           input logic [3:0] fl, input logic [1:0] fa, input logic [1:0] fb);
        chk({tag, ".req"},   32'(hz.dmem_req), 32'(req));
        chk({tag, ".stall"}, 32'({hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m}), 32'(st));
        chk({tag, ".flush"}, 32'({hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w}), 32'(fl));
        chk({tag, ".fwd_a"}, 32'(hz.fwd_a_e), 32'(fa));
        chk({tag, ".fwd_b"}, 32'(hz.fwd_b_e), 32'(fb));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0;
        hz.rd_e  = '0; hz.rd_m  = '0; hz.rd_w  = '0;
        hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0;
        hz.load_e = 1'b0; hz.pcsrc_e = 1'b0;
        hz.memacc_m = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic wm, input logic ww);
        if (rs == 5'd0)              return 2'b00;
        if (wm && rs == rdm)         return 2'b10;
        if (ww && rs == rdw)         return 2'b01;
        return 2'b00;
    endfunction

    // ---------------- reference model state ----------------
    bit          m_init;      // first cycle after reset release
    bit          m_pending;   // a data access is outstanding from an earlier cycle
    logic [31:0] m_scnt;
    logic [31:0] m_fcnt;

    initial begin
        total = 0;
        bad   = 0;

        // vector table, applied one cycle each in RUN
        //          rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw  rwm rww ld br ma rdy | req stall    flush    fa     fb
        vt[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 2'b10, 2'b00};
        vt[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 2'b01, 2'b00};
        vt[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 2'b00, 2'b00};
        vt[3]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 0, 1, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 2'b01, 2'b01};
        vt[4]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 2'b10, 2'b10};
        vt[5]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0,  0, 4'b1100, 4'b0100, 2'b00, 2'b00};
        vt[6]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0,  0, 4'b0000, 4'b1100, 2'b00, 2'b00};
        vt[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0,  0, 4'b0000, 4'b0000, 2'b00, 2'b00};
        vt[8]  = '{5'd4, 5'd1, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0,  0, 4'b1100, 4'b0100, 2'b00, 2'b00};
        vt[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0,  0, 4'b0000, 4'b1100, 2'b00, 2'b00};
        vt[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1,  1, 4'b0000, 4'b0000, 2'b00, 2'b00};
        vt[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1,  1, 4'b0000, 4'b1100, 2'b00, 2'b00};
        vt[12] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 2'b00, 2'b00};

        // ---------------- reset and INIT bubble ----------------
        idle_inputs();
        rst_n = 1'b0;
        hz.memacc_m = 1'b1;
        hz.rs1_e = 5'd5; hz.rd_m = 5'd5; hz.regwrite_m = 1'b1;
        #3;
        chk_all("reset", 1'b0, 4'b1111, 4'b1111, 2'b00, 2'b00);
        tick();
        tick();
        rst_n = 1'b1;
        #3;
        chk_all("init", 1'b0, 4'b1000, 4'b1111, 2'b10, 2'b00);
        tick();
        idle_inputs();
        #3;
        chk_all("run0", 1'b0, 4'b0000, 4'b0000, 2'b00, 2'b00);
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < 13; i++) begin
            hz.rs1_d = vt[i].rs1_d; hz.rs2_d = vt[i].rs2_d;
            hz.rs1_e = vt[i].rs1_e; hz.rs2_e = vt[i].rs2_e;
            hz.rd_e  = vt[i].rd_e;  hz.rd_m  = vt[i].rd_m; hz.rd_w = vt[i].rd_w;
            hz.regwrite_m = vt[i].rwm; hz.regwrite_w = vt[i].rww;
            hz.load_e = vt[i].load; hz.pcsrc_e = vt[i].pcsrc;
            hz.memacc_m = vt[i].memacc; hz.dmem_ready = vt[i].ready;
            #3;
            chk_all($sformatf("vec%0d", i), vt[i].req, vt[i].stall, vt[i].flush, vt[i].fa, vt[i].fb);
            tick();
        end
        idle_inputs();

        // ---------------- 3-cycle memory wait ----------------
        hz.memacc_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // a load-use hazard during the wait must be suppressed
            hz.load_e = (i == 1); hz.rd_e = 5'd2; hz.rs1_d = 5'd2;
            #3;
            chk_all($sformatf("wait%0d", i), 1'b1, 4'b1111, 4'b0001, 2'b00, 2'b00);
            tick();
        end
        hz.load_e = 1'b0;
        hz.dmem_ready = 1'b1;
        #3;
        chk_all("wait_done", 1'b1, 4'b0000, 4'b0000, 2'b00, 2'b00);
        tick();
        idle_inputs();
        #3;
        chk_all("wait_back_run", 1'b0, 4'b0000, 4'b0000, 2'b00, 2'b00);
        tick();

        // ---------------- branch during a wait ----------------
        hz.memacc_m = 1'b1; hz.pcsrc_e = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk_all($sformatf("brwait%0d", i), 1'b1, 4'b1111, 4'b0001, 2'b00, 2'b00);
            tick();
        end
        hz.dmem_ready = 1'b1;
        #3;
        chk_all("brwait_done", 1'b1, 4'b0000, 4'b1100, 2'b00, 2'b00);
        tick();
        idle_inputs();
        #3;
        chk_all("brwait_after", 1'b0, 4'b0000, 4'b0000, 2'b00, 2'b00);
        tick();

        // ---------------- reset during DWAIT ----------------
        hz.memacc_m = 1'b1;
        tick();
        hz.memacc_m = 1'b0;      // request held by the pending access
        #1;
        chk("dwait_req_held", 32'(hz.dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all("dwait_reset", 1'b0, 4'b1111, 4'b1111, 2'b00, 2'b00);
        tick();
        rst_n = 1'b1;
        #3;
        chk_all("dwait_reinit", 1'b0, 4'b1000, 4'b1111, 2'b00, 2'b00);
        tick();

        // fresh 3-cycle wait after reset, for the counters
        hz.memacc_m = 1'b1;
        repeat (3) tick();
        hz.dmem_ready = 1'b1;
        tick();
        idle_inputs();
        #3;
        chk_all("post_reset_run", 1'b0, 4'b0000, 4'b0000, 2'b00, 2'b00);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt3", stall_cnt, 32'd3);
        chk("flush_cnt0", flush_cnt, 32'd0);
        m_scnt = 32'd3;
        m_fcnt = 32'd0;
`else
        m_scnt = 32'd0;
        m_fcnt = 32'd0;
`endif
        tick();

        // ---------------- randomized traffic vs model ----------------
        m_init = 1'b0;
        m_pending = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic        e_req;
            logic [3:0]  e_st, e_fl;
            logic        lduse, memstall;

            rst_n = ($urandom_range(0, 49) != 0);
            hz.rs1_d = 5'($urandom_range(0, 3)); hz.rs2_d = 5'($urandom_range(0, 3));
            hz.rs1_e = 5'($urandom_range(0, 3)); hz.rs2_e = 5'($urandom_range(0, 3));
            hz.rd_e  = 5'($urandom_range(0, 3)); hz.rd_m  = 5'($urandom_range(0, 3));
            hz.rd_w  = 5'($urandom_range(0, 3));
            hz.regwrite_m = 1'($urandom_range(0, 1)); hz.regwrite_w = 1'($urandom_range(0, 1));
            hz.load_e  = 1'($urandom_range(0, 1));
            hz.pcsrc_e = ($urandom_range(0, 4) == 0);
            hz.memacc_m = m_pending ? 1'b1 : ($urandom_range(0, 2) == 0);
            hz.dmem_ready = 1'($urandom_range(0, 1));

            e_req = 1'b0; e_st = 4'b0000; e_fl = 4'b0000;
            lduse = hz.load_e && hz.rd_e != 0 && (hz.rs1_d == hz.rd_e || hz.rs2_d == hz.rd_e);
            memstall = 1'b0;
            if (!rst_n) begin
                e_st = 4'b1111; e_fl = 4'b1111;
            end else if (m_init) begin
                e_st = 4'b1000; e_fl = 4'b1111;
            end else begin
                e_req = m_pending || hz.memacc_m;
                memstall = e_req && !hz.dmem_ready;
                if (memstall)          begin e_st = 4'b1111; e_fl = 4'b0001; end
                else if (hz.pcsrc_e)   begin e_fl = 4'b1100; end
                else if (lduse)        begin e_st = 4'b1100; e_fl = 4'b0100; end
            end
            #3;
            chk_all($sformatf("rnd%0d", n), e_req, e_st, e_fl,
                    rst_n ? fwd_ref(hz.rs1_e, hz.rd_m, hz.rd_w, hz.regwrite_m, hz.regwrite_w) : 2'b00,
                    rst_n ? fwd_ref(hz.rs2_e, hz.rd_m, hz.rd_w, hz.regwrite_m, hz.regwrite_w) : 2'b00);
`ifdef PIPE_PERF_CNT_EN
            chk($sformatf("rnd%0d.stall_cnt", n), stall_cnt, rst_n ? m_scnt : 32'd0);
            chk($sformatf("rnd%0d.flush_cnt", n), flush_cnt, rst_n ? m_fcnt : 32'd0);
`endif
            // advance the model to the next cycle
            if (!rst_n) begin
                m_init = 1'b1; m_pending = 1'b0; m_scnt = '0; m_fcnt = '0;
            end else if (m_init) begin
                m_init = 1'b0;
            end else begin
                if (e_st[3]) m_scnt = m_scnt + 1;
                if (e_fl[3]) m_fcnt = m_fcnt + 1;
                m_pending = memstall;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
